// File: rtl/instruction_fetch_unit.sv
// Fetch-stage engine: owns the PC, issues BUSYWAIT-handshaked IMEM reads and
// feeds a one-entry slot to IF/ID. Optional macro: IF_BUBBLE_NOP_EN (NOP on redirect).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] OUT_INSTRUCTION,
  output logic [31:0] OUT_PC,
  output logic        OUT_BUSYWAIT
);

`ifdef IF_BUBBLE_NOP_EN
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`endif

  typedef enum logic [1:0] {FETCH, BUSY, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] disc_addr;
  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic        valid_r;
  logic        imem_read;
  logic        consume;

  assign consume = valid_r & ~STALL;

  // A full slot that cannot drain blocks new requests; BUSY/DISCARD must hold READ.
  always_comb begin
    case (state)
      FETCH:   imem_read = ~RESET & (~valid_r | ~STALL);
      default: imem_read = ~RESET;
    endcase
  end

  assign IMEM_READ       = imem_read;
  assign IMEM_ADDRESS    = (state == DISCARD) ? disc_addr : pc;
  assign OUT_INSTRUCTION = instr_r;
  assign OUT_PC          = pc_r;
  assign OUT_BUSYWAIT    = ~valid_r | STALL | RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      disc_addr <= '0;
      instr_r   <= '0;
      pc_r      <= '0;
      valid_r   <= 1'b0;
    end else begin
      if (consume) valid_r <= 1'b0;
      if (BRANCH_TAKEN) begin
        pc <= BRANCH_TARGET;
`ifdef IF_BUBBLE_NOP_EN
        instr_r <= NOP_INSTR;
        pc_r    <= BRANCH_TARGET;
        valid_r <= 1'b1;
`else
        valid_r <= 1'b0;
`endif
        // An in-flight request must still be retired on its old address.
        case (state)
          FETCH: begin
            if (imem_read && IMEM_BUSYWAIT) begin
              state     <= DISCARD;
              disc_addr <= pc;
            end
          end
          BUSY: begin
            if (IMEM_BUSYWAIT) begin
              state     <= DISCARD;
              disc_addr <= pc;
            end else begin
              state <= FETCH;
            end
          end
          default: if (!IMEM_BUSYWAIT) state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (imem_read) begin
              if (!IMEM_BUSYWAIT) begin
                instr_r <= IMEM_READDATA;
                pc_r    <= pc;
                valid_r <= 1'b1;
                pc      <= pc + 32'd4;
              end else begin
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            if (!IMEM_BUSYWAIT) begin
              instr_r <= IMEM_READDATA;
              pc_r    <= pc;
              valid_r <= 1'b1;
              pc      <= pc + 32'd4;
              state   <= FETCH;
            end
          end
          default: if (!IMEM_BUSYWAIT) state <= FETCH;
        endcase
      end
    end
  end

endmodule
